// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Pipeline hazard controller for the 5-stage RV32I core. Produces hold and
//   clear controls for the pipeline registers. It covers load-use bubbles,
//   taken-branch flushes and data-memory waits. A watchdog flags memory waits
//   that run too long. Two saturating counters track stall and flush cycles.
//
// Ports
//   clk, rst_n          core clock (rising edge), async active-low reset
//   inst_d, inst_e      instructions held in IF/ID and ID/EX
//   br_taken            branch/jump resolved taken in execute
//   mem_req_m           load/store occupies the memory stage
//   dmem_ready          data memory completes the access this cycle
//   err_clr             clears the sticky mem_timeout flag
//   stall_f..stall_m    hold PC, IF/ID, ID/EX, EX/MEM+MEM/WB
//   flush_d, flush_e    load NOP into IF/ID, ID/EX
//   mem_timeout         sticky watchdog flag
//   stall_cnt/flush_cnt saturating cycle counters for stall_f / flush_d
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | no memory wait in progress; wait_cnt is 0
// MEM_WAIT | memory access outstanding, counting stalled cycles
// TIMEOUT  | watchdog expired, still stalling until dmem_ready

module hazard_stall_unit #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst_d,
    input  logic [31:0]      inst_e,
    input  logic             br_taken,
    input  logic             mem_req_m,
    input  logic             dmem_ready,
    input  logic             err_clr,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WC_W = $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MAX_WAIT - 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [WC_W-1:0] wait_cnt;
    logic            mem_wait;
    logic            load_use;
    logic            uses_rs1;
    logic            uses_rs2;

    // Fields of the instructions that the hazard check never looks at.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst_d[31:25], inst_d[14:7], inst_e[31:12]};

    logic [6:0] op_d;
    logic [6:0] op_e;
    logic [4:0] rd_e;
    assign op_d = inst_d[6:0];
    assign op_e = inst_e[6:0];
    assign rd_e = inst_e[11:7];

    assign uses_rs1 = (op_d == OP_OP) || (op_d == OP_OPIMM) || (op_d == OP_LOAD) ||
                      (op_d == OP_STORE) || (op_d == OP_BRANCH) || (op_d == OP_JALR);
    assign uses_rs2 = (op_d == OP_OP) || (op_d == OP_STORE) || (op_d == OP_BRANCH);

    assign load_use = (op_e == OP_LOAD) && (rd_e != 5'd0) &&
                      ((uses_rs1 && (inst_d[19:15] == rd_e)) ||
                       (uses_rs2 && (inst_d[24:20] == rd_e)));

    // Once a wait has started, only dmem_ready ends it; mem_req_m may drop.
    assign mem_wait = (state == RUN) ? (mem_req_m && !dmem_ready) : !dmem_ready;

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                // With MAX_WAIT == 1 the very first stalled cycle is the last one.
                if (mem_wait) begin
                    state_next = (wait_cnt == WAIT_LAST) ? TIMEOUT : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_next = RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = TIMEOUT;
                end
            end
            TIMEOUT: begin
                if (dmem_ready) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (!rst_n) begin
            // hold everything released while in reset
        end else if (mem_wait) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (br_taken) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state <= state_next;

            if (state_next == RUN) begin
                wait_cnt <= '0;
            end else if (state != TIMEOUT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if ((state_next == TIMEOUT) && (state != TIMEOUT)) begin
                mem_timeout <= 1'b1;
            end else if (err_clr) begin
                mem_timeout <= 1'b0;
            end

            if (stall_f && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_d && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Testbench for hazard_stall_unit: two instances (default parameters and a
// small one with MAX_WAIT=3, CNT_W=2) share one stimulus stream and are
// compared every cycle against a cycle-level model of the hazard rules.
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_d, inst_e;
    logic        br_taken, mem_req_m, dmem_ready, err_clr;

    // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_timeout}
    wire  [6:0]  ctl_a, ctl_b;
    wire  [15:0] sc_a, fc_a;
    wire  [1:0]  sc_b, fc_b;

    hazard_stall_unit #(.CNT_W(16), .MAX_WAIT(15)) dut_a (
        .clk(clk), .rst_n(rst_n), .inst_d(inst_d), .inst_e(inst_e),
        .br_taken(br_taken), .mem_req_m(mem_req_m), .dmem_ready(dmem_ready),
        .err_clr(err_clr),
        .stall_f(ctl_a[6]), .stall_d(ctl_a[5]), .stall_e(ctl_a[4]), .stall_m(ctl_a[3]),
        .flush_d(ctl_a[2]), .flush_e(ctl_a[1]), .mem_timeout(ctl_a[0]),
        .stall_cnt(sc_a), .flush_cnt(fc_a)
    );

    hazard_stall_unit #(.CNT_W(2), .MAX_WAIT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .inst_d(inst_d), .inst_e(inst_e),
        .br_taken(br_taken), .mem_req_m(mem_req_m), .dmem_ready(dmem_ready),
        .err_clr(err_clr),
        .stall_f(ctl_b[6]), .stall_d(ctl_b[5]), .stall_e(ctl_b[4]), .stall_m(ctl_b[3]),
        .flush_d(ctl_b[2]), .flush_e(ctl_b[1]), .mem_timeout(ctl_b[0]),
        .stall_cnt(sc_b), .flush_cnt(fc_b)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    localparam int MWV  [2] = '{15, 3};
    localparam int CMAX [2] = '{65535, 3};

    // model state per instance
    int in_wait [2];
    int k       [2];
    int flag    [2];
    int sc      [2];
    int fc      [2];

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
        mk = {7'b0, 5'(rs2), 5'(rs1), 3'b010, 5'(rd), op};
    endfunction

    function automatic logic lu();
        logic [6:0] opd;
        logic [4:0] rd;
        logic       u1, u2;
        opd = inst_d[6:0];
        rd  = inst_e[11:7];
        u1  = opd inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
        u2  = opd inside {7'b0110011, 7'b0100011, 7'b1100011};
        lu  = (inst_e[6:0] == 7'b0000011) && (rd != 5'd0) &&
              ((u1 && inst_d[19:15] == rd) || (u2 && inst_d[24:20] == rd));
    endfunction

    function automatic logic [6:0] exp_ctl(input int p);
        logic mw;
        logic f;
        f = (flag[p] != 0);
        if (!rst_n) return 7'b0;
        mw = (in_wait[p] != 0) ? !dmem_ready : (mem_req_m && !dmem_ready);
        if (mw)            return {4'b1111, 2'b00, f};
        else if (br_taken) return {4'b0000, 2'b11, f};
        else if (lu())     return {4'b1100, 2'b01, f};
        else               return {6'b0, f};
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            in_wait[p] = 0; k[p] = 0; flag[p] = 0; sc[p] = 0; fc[p] = 0;
        end
    endtask

    task automatic model_update();
        logic [6:0] e;
        int set;
        for (int p = 0; p < 2; p++) begin
            if (!rst_n) begin
                in_wait[p] = 0; k[p] = 0; flag[p] = 0; sc[p] = 0; fc[p] = 0;
            end else begin
                e = exp_ctl(p);
                if (e[6] && sc[p] < CMAX[p]) sc[p]++;
                if (e[2] && fc[p] < CMAX[p]) fc[p]++;
                set = 0;
                if (e[3]) begin
                    // stall cycle number k+1; the MAX_WAIT-th one arms the watchdog
                    if (k[p] + 1 == MWV[p]) set = 1;
                    k[p]++;
                    in_wait[p] = 1;
                end else begin
                    k[p] = 0;
                    in_wait[p] = 0;
                end
                if (set != 0)     flag[p] = 1;
                else if (err_clr) flag[p] = 0;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // one clock cycle: compare at the falling edge, advance the model at the rising edge
    task automatic step();
        @(negedge clk);
        chk("ctl_a", int'(ctl_a), int'(exp_ctl(0)));
        chk("ctl_b", int'(ctl_b), int'(exp_ctl(1)));
        chk("stall_cnt_a", int'(sc_a), sc[0]);
        chk("flush_cnt_a", int'(fc_a), fc[0]);
        chk("stall_cnt_b", int'(sc_b), sc[1]);
        chk("flush_cnt_b", int'(fc_b), fc[1]);
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; inst_d = NOP; inst_e = NOP;
        br_taken = 1'b0; mem_req_m = 1'b0; dmem_ready = 1'b0; err_clr = 1'b0;
        model_reset();
        // reset with active-looking inputs: outputs must stay low
        mem_req_m = 1'b1; br_taken = 1'b1;
        #1;
        chk("reset_ctl_a", int'(ctl_a), 0);
        step(); step();
        chk("reset_cnt_a", int'(sc_a), 0);
        mem_req_m = 1'b0; br_taken = 1'b0; dmem_ready = 1'b1;
        rst_n = 1'b1;
        step();

        // load-use on rs1: lw x5 ; add x6,x5,x1
        inst_e = mk(7'b0000011, 5, 1, 0);
        inst_d = mk(7'b0110011, 6, 5, 1);
        #1;
        chk("lu_ctl_a", int'(ctl_a), 7'b1100010);
        step();
        inst_e = NOP;
        step();
        chk("lu_stall_cnt_a", int'(sc_a), 1);

        // lw x5 followed by lui x5 (fields look like x5 but are not sources)
        inst_e = mk(7'b0000011, 5, 1, 0);
        inst_d = mk(7'b0110111, 5, 5, 5);
        #1;
        chk("lui_ctl_a", int'(ctl_a), 0);
        step();
        // lw x0 ; add x1,x0,x0
        inst_e = mk(7'b0000011, 0, 1, 0);
        inst_d = mk(7'b0110011, 1, 0, 0);
        #1;
        chk("x0_ctl_a", int'(ctl_a), 0);
        step();

        // branch taken together with a load-use match
        inst_e = mk(7'b0000011, 5, 1, 0);
        inst_d = mk(7'b0110011, 6, 5, 1);
        br_taken = 1'b1;
        #1;
        chk("br_lu_ctl_a", int'(ctl_a), 7'b0000110);
        step();
        br_taken = 1'b0; inst_e = NOP; inst_d = NOP;
        chk("br_flush_cnt_a", int'(fc_a), 1);
        chk("br_stall_cnt_a", int'(sc_a), 1);

        // memory wait: 4 cycles not ready, released in the 5th
        mem_req_m = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        dmem_ready = 1'b1;
        #1;
        chk("mw_release_ctl_a", int'(ctl_a), 0);
        step();
        mem_req_m = 1'b0;
        chk("mw_stall_cnt_a", int'(sc_a), 5);
        chk("mw_timeout_a", int'(ctl_a[0]), 0);
        chk("mw_timeout_b", int'(ctl_b[0]), 1);
        chk("mw_stall_cnt_b_sat", int'(sc_b), 3);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_timeout_b", int'(ctl_b[0]), 0);

        // timeout: 6 cycles not ready, branch held in execute throughout
        mem_req_m = 1'b1; dmem_ready = 1'b0; br_taken = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            err_clr = (c == 3 || c == 5);   // cycle 3 collides with the set edge
            #1;
            if (c == 4) chk("to_cycle4_ctl_b", int'(ctl_b), 7'b1111001);
            if (c == 6) chk("to_cycle6_ctl_b", int'(ctl_b), 7'b1111000);
            step();
        end
        err_clr = 1'b0;
        dmem_ready = 1'b1;
        #1;
        chk("to_release_ctl_a", int'(ctl_a), 7'b0000110);
        step();
        br_taken = 1'b0; mem_req_m = 1'b0;
        chk("to_stall_cnt_a", int'(sc_a), 11);
        chk("to_flush_cnt_a", int'(fc_a), 2);
        step();

        // async reset dropped during cycle 2 of a memory wait
        mem_req_m = 1'b1; dmem_ready = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_ctl_a", int'(ctl_a), 0);
        chk("arst_ctl_b", int'(ctl_b), 0);
        chk("arst_cnt_a", int'(sc_a), 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("rearm_timeout_b", int'(ctl_b[0]), 1);
        chk("rearm_timeout_a", int'(ctl_a[0]), 0);
        dmem_ready = 1'b1;
        step();
        mem_req_m = 1'b0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // counter saturation: 5 load-use stalls, alternating rs1 and rs2 matches
        for (int i = 0; i < 5; i++) begin
            inst_e = mk(7'b0000011, 7, 1, 0);
            if (i % 2 == 0) inst_d = mk(7'b0110011, 3, 7, 2);
            else            inst_d = mk(7'b0100011, 0, 2, 7);
            step();
            inst_e = NOP;
            step();
        end
        chk("sat_stall_cnt_b", int'(sc_b), 3);
        chk("sat_stall_cnt_a", int'(sc_a), 9);
        inst_d = NOP;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
